// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acq_pkg
//  Description : Shared state encoding, mode constants and default widths
//                for the acquisition sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int GAP_W_DEF = 32;
    localparam int TMO_W_DEF = 24;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_CONT   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ARM        = 4'd1,
        ST_WAIT_FRAME = 4'd2,
        ST_IN_FRAME   = 4'd3,
        ST_GAP        = 4'd4,
        ST_DONE       = 4'd5,
        ST_ERROR      = 4'd6
    } acq_state_t;

endpackage
`default_nettype wire

// File: rtl/acq_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_down_timer
//  Description : Loadable down-counter that stops at zero.
//  Ports       : master_clock, resetn  - clock / async active-low reset
//                i_load, i_load_value  - load (priority over enable)
//                i_enable              - decrement while nonzero
//                o_zero                - counter is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_down_timer
    import acq_pkg::*;
#(
    parameter int W = TMO_W_DEF
) (
    input  logic         master_clock,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_enable,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer
//  Description : Control-plane sequencer for the acquisition / AXIS
//                packetiser datapath. Gates frame capture, counts frames,
//                enforces per-phase timeouts and reports status.
//  Ports       : master_clock, resetn        - clock / async active-low reset
//                cmd_start, cmd_stop         - software command pulses
//                cfg_*                       - configuration (latched on start)
//                frame_sync, frame_done      - datapath frame events
//                acq_enable, send_raw_data,
//                number_of_packet            - datapath control
//                busy, done_pulse, timeout_err,
//                frames_done, dbg_state      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic             master_clock,
    input  logic             resetn,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_raw,
    input  logic [CNT_W-1:0] cfg_frame_count,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             frame_sync,
    input  logic             frame_done,
    output logic             acq_enable,
    output logic             send_raw_data,
    output logic [15:0]      number_of_packet,
    output logic             busy,
    output logic             done_pulse,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frames_done,
    output logic [3:0]       dbg_state
);

    acq_state_t       r_state;
    logic [1:0]       r_cfg_mode;
    logic [CNT_W-1:0] r_cfg_count;
    logic [CNT_W-1:0] r_eff_count;
    logic [GAP_W-1:0] r_cfg_gap;
    logic [TMO_W-1:0] r_cfg_timeout;
    logic             r_stop_pending;

    logic             w_burst;
    logic             w_single;
    logic [CNT_W-1:0] w_eff_count;
    logic [CNT_W-1:0] w_frames_next;
    logic             w_last_frame;
    logic             w_frame_end;
    logic             w_tmo_zero;
    logic             w_tmo_expired;
    logic             w_tmo_load;
    logic             w_tmo_en;
    logic             w_gap_zero;
    logic [GAP_W-1:0] w_gap_load_value;

    assign w_burst  = (r_cfg_mode == MODE_BURST);
    // Reserved mode 3 behaves as single.
    assign w_single = !w_burst && (r_cfg_mode != MODE_CONT);

    assign w_eff_count   = (r_cfg_count == '0) ? CNT_W'(1) : r_cfg_count;
    assign w_frames_next = (&frames_done) ? frames_done : frames_done + CNT_W'(1);

    assign w_last_frame = w_single || (w_burst && (w_frames_next == r_eff_count)) ||
                          r_stop_pending || cmd_stop;

    // A frame ends on frame_done in IN_FRAME, or on sync+done arriving
    // together in WAIT_FRAME (a stop in that cycle takes precedence).
    assign w_frame_end = ((r_state == ST_IN_FRAME) && frame_done) ||
                         ((r_state == ST_WAIT_FRAME) && frame_sync && frame_done && !cmd_stop);

    // Timeout counter is reloaded on every entry into WAIT_FRAME or IN_FRAME.
    assign w_tmo_load = (r_state == ST_ARM) ||
                        ((r_state == ST_GAP) && w_gap_zero) ||
                        ((r_state == ST_WAIT_FRAME) && frame_sync) ||
                        ((r_state == ST_IN_FRAME) && frame_done);
    assign w_tmo_en      = (r_state == ST_WAIT_FRAME) || (r_state == ST_IN_FRAME);
    assign w_tmo_expired = (r_cfg_timeout != '0) && w_tmo_zero;

    // GAP leaves when the counter reads zero, so loading gap-1 yields
    // exactly cfg_gap cycles in GAP.
    assign w_gap_load_value = (r_cfg_gap == '0) ? '0 : r_cfg_gap - GAP_W'(1);

    acq_down_timer #(.W(TMO_W)) u_tmo_timer (
        .master_clock (master_clock),
        .resetn       (resetn),
        .i_load       (w_tmo_load),
        .i_load_value (r_cfg_timeout),
        .i_enable     (w_tmo_en),
        .o_zero       (w_tmo_zero)
    );

    acq_down_timer #(.W(GAP_W)) u_gap_timer (
        .master_clock (master_clock),
        .resetn       (resetn),
        .i_load       (w_frame_end),
        .i_load_value (w_gap_load_value),
        .i_enable     (r_state == ST_GAP),
        .o_zero       (w_gap_zero)
    );

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_cfg_mode       <= '0;
            r_cfg_count      <= '0;
            r_eff_count      <= '0;
            r_cfg_gap        <= '0;
            r_cfg_timeout    <= '0;
            r_stop_pending   <= 1'b0;
            acq_enable       <= 1'b0;
            send_raw_data    <= 1'b0;
            number_of_packet <= '0;
            busy             <= 1'b0;
            done_pulse       <= 1'b0;
            timeout_err      <= 1'b0;
            frames_done      <= '0;
        end else if (w_frame_end) begin
            frames_done <= w_frames_next;
            acq_enable  <= 1'b0;
            if (w_last_frame) begin
                r_state    <= ST_DONE;
                done_pulse <= 1'b1;
            end else if (r_cfg_gap == '0) begin
                r_state    <= ST_WAIT_FRAME;
                acq_enable <= 1'b1;
            end else begin
                r_state <= ST_GAP;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done_pulse <= 1'b0;
                    acq_enable <= 1'b0;
                    if (cmd_start && !cmd_stop) begin
                        r_state       <= ST_ARM;
                        busy          <= 1'b1;
                        frames_done   <= '0;
                        timeout_err   <= 1'b0;
                        r_cfg_mode    <= cfg_mode;
                        send_raw_data <= cfg_raw;
                        r_cfg_count   <= cfg_frame_count;
                        r_cfg_gap     <= cfg_gap;
                        r_cfg_timeout <= cfg_timeout;
                    end
                end
                ST_ARM: begin
                    r_eff_count      <= w_eff_count;
                    number_of_packet <= w_burst ? 16'(w_eff_count - CNT_W'(1)) : 16'd0;
                    r_state          <= ST_WAIT_FRAME;
                    acq_enable       <= 1'b1;
                end
                ST_WAIT_FRAME: begin
                    if (cmd_stop) begin
                        r_state    <= ST_DONE;
                        acq_enable <= 1'b0;
                        done_pulse <= 1'b1;
                    end else if (frame_sync) begin
                        r_state    <= ST_IN_FRAME;
                        acq_enable <= 1'b0;
                    end else if (w_tmo_expired) begin
                        r_state     <= ST_ERROR;
                        acq_enable  <= 1'b0;
                        done_pulse  <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                ST_IN_FRAME: begin
                    if (cmd_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_tmo_expired) begin
                        r_state     <= ST_ERROR;
                        done_pulse  <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cmd_stop) begin
                        r_state    <= ST_DONE;
                        done_pulse <= 1'b1;
                    end else if (w_gap_zero) begin
                        r_state    <= ST_WAIT_FRAME;
                        acq_enable <= 1'b1;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    r_state        <= ST_IDLE;
                    done_pulse     <= 1'b0;
                    busy           <= 1'b0;
                    r_stop_pending <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acq_sequencer
//  Description : Directed self-checking bench for acq_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

    logic        master_clock;
    logic        resetn;
    logic        cmd_start;
    logic        cmd_stop;
    logic [1:0]  cfg_mode;
    logic        cfg_raw;
    logic [15:0] cfg_frame_count;
    logic [31:0] cfg_gap;
    logic [23:0] cfg_timeout;
    logic        frame_sync;
    logic        frame_done;
    logic        acq_enable;
    logic        send_raw_data;
    logic [15:0] number_of_packet;
    logic        busy;
    logic        done_pulse;
    logic        timeout_err;
    logic [15:0] frames_done;
    logic [3:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    acq_sequencer #(.CNT_W(16), .GAP_W(32), .TMO_W(24)) dut (
        .master_clock     (master_clock),
        .resetn           (resetn),
        .cmd_start        (cmd_start),
        .cmd_stop         (cmd_stop),
        .cfg_mode         (cfg_mode),
        .cfg_raw          (cfg_raw),
        .cfg_frame_count  (cfg_frame_count),
        .cfg_gap          (cfg_gap),
        .cfg_timeout      (cfg_timeout),
        .frame_sync       (frame_sync),
        .frame_done       (frame_done),
        .acq_enable       (acq_enable),
        .send_raw_data    (send_raw_data),
        .number_of_packet (number_of_packet),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .timeout_err      (timeout_err),
        .frames_done      (frames_done),
        .dbg_state        (dbg_state)
    );

    initial master_clock = 1'b0;
    always #5 master_clock = ~master_clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge master_clock);
        #1;
    endtask

    task automatic start_seq(input logic [1:0] mode, input logic raw, input logic [15:0] cnt,
                             input logic [31:0] gap, input logic [23:0] tmo);
        cfg_mode = mode; cfg_raw = raw; cfg_frame_count = cnt; cfg_gap = gap; cfg_timeout = tmo;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1; tick(); frame_done = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] outs;
        resetn = 1'b0; cmd_start = 0; cmd_stop = 0; frame_sync = 0; frame_done = 0;
        cfg_mode = 0; cfg_raw = 0; cfg_frame_count = 0; cfg_gap = 0; cfg_timeout = 0;
        repeat (3) tick();
        outs = {acq_enable, send_raw_data, number_of_packet, busy, done_pulse, timeout_err, frames_done, dbg_state};
        checks++; if (outs !== 42'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        resetn = 1'b1;
        tick();
        checks++; if (dbg_state !== 4'd0) begin errors++; $display("FAIL reset_idle: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_single();
        start_seq(2'd0, 1'b1, 16'd5, 32'd7, 24'd0);
        checks++; if (dbg_state !== 4'd1) begin errors++; $display("FAIL single_arm: got %0d expected 1", dbg_state); end
        checks++; if (acq_enable !== 1'b0) begin errors++; $display("FAIL single_en_c1: got %b expected 0", acq_enable); end
        tick();
        checks++; if (acq_enable !== 1'b1) begin errors++; $display("FAIL single_en_c2: got %b expected 1", acq_enable); end
        checks++; if (send_raw_data !== 1'b1) begin errors++; $display("FAIL single_raw: got %b expected 1", send_raw_data); end
        checks++; if (number_of_packet !== 16'd0) begin errors++; $display("FAIL single_nop: got %0d expected 0", number_of_packet); end
        repeat (8) tick();
        pulse_sync();
        cfg_raw = 1'b0;
        checks++; if (acq_enable !== 1'b0) begin errors++; $display("FAIL single_en_after_sync: got %b expected 0", acq_enable); end
        checks++; if (dbg_state !== 4'd3) begin errors++; $display("FAIL single_in_frame: got %0d expected 3", dbg_state); end
        repeat (1988) tick();
        checks++; if (send_raw_data !== 1'b1) begin errors++; $display("FAIL single_shadow: got %b expected 1", send_raw_data); end
        pulse_done();
        checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b expected 1", done_pulse); end
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", frames_done); end
        tick();
        checks++; if ({busy, done_pulse, dbg_state} !== 6'd0) begin errors++; $display("FAIL single_back_idle: got %b/%b/%0d expected 0/0/0", busy, done_pulse, dbg_state); end
    endtask

    task automatic test_burst();
        int n;
        int w;
        int pulses;
        pulses = 0;
        start_seq(2'd1, 1'b0, 16'd3, 32'd100, 24'd0);
        tick();
        checks++; if (number_of_packet !== 16'd2) begin errors++; $display("FAIL burst_nop: got %0d expected 2", number_of_packet); end
        checks++; if (send_raw_data !== 1'b0) begin errors++; $display("FAIL burst_raw: got %b expected 0", send_raw_data); end
        for (int f = 0; f < 3; f++) begin
            w = 0;
            while (!acq_enable && w < 500) begin tick(); w++; end
            checks++; if (acq_enable !== 1'b1) begin errors++; $display("FAIL burst_wait_en f%0d: got %b expected 1", f, acq_enable); end
            pulse_sync();
            pulse_done();
            if (done_pulse) pulses++;
            checks++; if (frames_done !== 16'(f + 1)) begin errors++; $display("FAIL burst_frames f%0d: got %0d expected %0d", f, frames_done, f + 1); end
            if (f < 2) begin
                n = 0;
                while (dbg_state == 4'd4 && !acq_enable && n < 1000) begin n++; tick(); end
                checks++; if (n !== 100) begin errors++; $display("FAIL burst_gap_len f%0d: got %0d expected 100", f, n); end
            end
        end
        checks++; if (dbg_state !== 4'd5) begin errors++; $display("FAIL burst_done_state: got %0d expected 5", dbg_state); end
        tick();
        if (done_pulse) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL burst_done_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_timeout();
        int n;
        start_seq(2'd0, 1'b0, 16'd1, 32'd0, 24'd500);
        tick();
        n = 0;
        while (dbg_state != 4'd6 && n < 1000) begin tick(); n++; end
        checks++; if (n + 1 !== 502) begin errors++; $display("FAIL timeout_cycle: got %0d expected 502", n + 1); end
        checks++; if ({timeout_err, done_pulse} !== 2'b11) begin errors++; $display("FAIL timeout_flags: got %b expected 11", {timeout_err, done_pulse}); end
        tick();
        checks++; if ({timeout_err, done_pulse, busy} !== 3'b100) begin errors++; $display("FAIL timeout_sticky: got %b expected 100", {timeout_err, done_pulse, busy}); end
        start_seq(2'd0, 1'b0, 16'd1, 32'd0, 24'd0);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_err); end
        tick();
        pulse_stop();
        checks++; if (dbg_state !== 4'd5) begin errors++; $display("FAIL stop_in_wait: got %0d expected 5", dbg_state); end
        tick();
    endtask

    task automatic test_continuous();
        int highs;
        start_seq(2'd2, 1'b1, 16'd2, 32'd0, 24'd0);
        tick();
        for (int f = 0; f < 6; f++) begin
            pulse_sync();
            if (f == 5) begin
                pulse_stop();
                checks++; if ({dbg_state, acq_enable} !== {4'd3, 1'b0}) begin errors++; $display("FAIL cont_stop_holds: got %0d/%b expected 3/0", dbg_state, acq_enable); end
                repeat (5) tick();
            end
            tick();
            pulse_done();
            if (f < 5) begin
                checks++; if ({dbg_state, acq_enable} !== {4'd2, 1'b1}) begin errors++; $display("FAIL cont_rearm f%0d: got %0d/%b expected 2/1", f, dbg_state, acq_enable); end
            end
        end
        checks++; if ({dbg_state, done_pulse} !== {4'd5, 1'b1}) begin errors++; $display("FAIL cont_done: got %0d/%b expected 5/1", dbg_state, done_pulse); end
        checks++; if (frames_done !== 16'd6) begin errors++; $display("FAIL cont_frames: got %0d expected 6", frames_done); end
        highs = 0;
        repeat (30) begin tick(); if (acq_enable || busy) highs++; end
        checks++; if (highs !== 0) begin errors++; $display("FAIL cont_quiet: got %0d expected 0", highs); end
    endtask

    task automatic test_start_stop_same();
        cmd_start = 1'b1; cmd_stop = 1'b1;
        tick();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        tick();
        checks++; if ({dbg_state, busy} !== 5'd0) begin errors++; $display("FAIL start_stop_same: got %0d/%b expected 0/0", dbg_state, busy); end
    endtask

    task automatic test_count_zero();
        start_seq(2'd1, 1'b1, 16'd0, 32'd10, 24'd0);
        tick();
        checks++; if (number_of_packet !== 16'd0) begin errors++; $display("FAIL count0_nop: got %0d expected 0", number_of_packet); end
        pulse_sync();
        pulse_done();
        checks++; if ({dbg_state, frames_done} !== {4'd5, 16'd1}) begin errors++; $display("FAIL count0_one_frame: got %0d/%0d expected 5/1", dbg_state, frames_done); end
        tick();
    endtask

    task automatic test_coincident();
        start_seq(2'd1, 1'b0, 16'd2, 32'd0, 24'd0);
        tick();
        frame_sync = 1'b1; frame_done = 1'b1;
        tick();
        frame_sync = 1'b0; frame_done = 1'b0;
        checks++; if ({dbg_state, acq_enable, frames_done} !== {4'd2, 1'b1, 16'd1}) begin errors++; $display("FAIL coinc_first: got %0d/%b/%0d expected 2/1/1", dbg_state, acq_enable, frames_done); end
        pulse_sync();
        pulse_done();
        checks++; if ({dbg_state, frames_done} !== {4'd5, 16'd2}) begin errors++; $display("FAIL coinc_second: got %0d/%0d expected 5/2", dbg_state, frames_done); end
        tick();
    endtask

    task automatic test_reset_mid_gap();
        logic [41:0] outs;
        start_seq(2'd1, 1'b1, 16'd3, 32'd50, 24'd0);
        tick();
        pulse_sync();
        pulse_done();
        repeat (5) tick();
        checks++; if (dbg_state !== 4'd4) begin errors++; $display("FAIL midgap_pre: got %0d expected 4", dbg_state); end
        resetn = 1'b0;
        #1;
        outs = {acq_enable, send_raw_data, number_of_packet, busy, done_pulse, timeout_err, frames_done, dbg_state};
        checks++; if (outs !== 42'd0) begin errors++; $display("FAIL midgap_async: got %h expected 0", outs); end
        tick(); tick();
        resetn = 1'b1;
        tick();
        checks++; if ({done_pulse, dbg_state} !== 5'd0) begin errors++; $display("FAIL midgap_after: got %b/%0d expected 0/0", done_pulse, dbg_state); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_timeout();
        test_continuous();
        test_start_stop_same();
        test_count_zero();
        test_coincident();
        test_reset_mid_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Control-plane sequencer for the S15611 acquisition/AXIS packetiser datapath.
- Accepts software start/stop commands and latched configuration: mode, raw/processed, frame count, inter-frame gap and timeout.
- Gates frame capture with acq_enable and drives the datapath's send_raw_data and number_of_packet.
- Counts completed frames, enforces per-frame timeouts and reports busy/done/error to the PS register bank.

Parameters:
- CNT_W, 16, width of frame counter and cfg_frame_count
- GAP_W, 32, width of inter-frame gap counter (master_clock cycles)
- TMO_W, 24, width of timeout counter (master_clock cycles)

Ports:
- master_clock  in  1  sole clock, 40 MHz
- resetn  in  1  asynchronous active-low reset
- cmd_start  in  1  single-cycle start pulse
- cmd_stop  in  1  single-cycle stop pulse
- cfg_mode  in  2  0=single, 1=burst, 2=continuous, 3=reserved (treated as single)
- cfg_raw  in  1  1=raw frames, 0=processed frames
- cfg_frame_count  in  CNT_W  frames per burst
- cfg_gap  in  GAP_W  idle cycles between frames
- cfg_timeout  in  TMO_W  max cycles per wait phase; 0 disables timeout
- frame_sync  in  1  pulse: datapath left IDLE (frame header issued)
- frame_done  in  1  pulse: footer beat accepted (tvalid&tready on footer)
- acq_enable  out  1  datapath may start a frame
- send_raw_data  out  1  latched cfg_raw
- number_of_packet  out  16  latched cfg_frame_count-1 (0 in single/continuous)
- busy  out  1  high in any state except IDLE
- done_pulse  out  1  one cycle at sequence completion
- timeout_err  out  1  sticky; cleared by next accepted cmd_start
- frames_done  out  CNT_W  frames completed in current sequence; saturating
- dbg_state  out  4  current state encoding

Behaviour:
- Reset values: all outputs 0; state IDLE. Async assert, synchronous release; reset mid-sequence aborts immediately with no done_pulse.
- All outputs registered.
- IDLE:
  - cmd_start=1 and cmd_stop=0 -> ARM. Clear frames_done and timeout_err; latch cfg_* into shadow registers.
  - cmd_start with cmd_stop in the same cycle is ignored.
- ARM (1 cycle):
  - Drive send_raw_data and number_of_packet from the shadow registers.
  - Effective count = max(cfg_frame_count, 1).
  - -> WAIT_FRAME.
  - acq_enable goes high at the edge after ARM, i.e. 2 cycles after cmd_start is sampled.
- WAIT_FRAME:
  - acq_enable=1; load timeout counter on entry.
  - frame_sync -> IN_FRAME.
  - Counter reaches 0 with timeout nonzero -> ERROR.
- IN_FRAME:
  - acq_enable=0 from the cycle after frame_sync, so no second frame starts.
  - Reload timeout counter.
  - On frame_done:
    - frames_done+1, saturating at all-ones.
    - Single mode, or frames_done+1 == effective count in burst mode -> DONE.
    - Otherwise cfg_gap==0 -> WAIT_FRAME, else -> GAP.
  - Timeout -> ERROR.
- GAP: down-count cfg_gap cycles, then -> WAIT_FRAME. acq_enable=0.
- cmd_stop while busy:
  - In WAIT_FRAME or GAP -> DONE next cycle.
  - In IN_FRAME -> set stop_pending; complete the current frame, then DONE regardless of mode/count.
- frame_sync and frame_done in the same cycle in WAIT_FRAME: treat as a complete frame; evaluate as IN_FRAME's frame_done.
- frame_done outside IN_FRAME (and not coincident as above): ignored.
- frame_sync outside WAIT_FRAME: ignored.
- DONE (1 cycle): done_pulse=1; -> IDLE. busy falls on the cycle after DONE.
- ERROR (1 cycle): timeout_err=1 (sticky), done_pulse=1; -> IDLE.
- cmd_start while busy: ignored.
- Config changes while busy: ignored (shadow registers).
- Continuous mode: runs until cmd_stop or timeout.
- Counters wrap: none. Gap and timeout counters load on entry and stop at 0.

Decomposition:
- Shared package acq_pkg:
  - State encoding: IDLE=0, ARM=1, WAIT_FRAME=2, IN_FRAME=3, GAP=4, DONE=5, ERROR=6.
  - Mode constants: MODE_SINGLE, MODE_BURST, MODE_CONT.
  - Default widths.
- Sub-module acq_down_timer: loadable down-counter with load, enable and zero flag. Instantiated twice: gap (GAP_W) and timeout (TMO_W).

Test Plan:
- Single, cfg_raw=1: start; frame_sync at +10, frame_done at +2000 -> acq_enable high at cycle 2, low after sync; frames_done=1; done_pulse once; send_raw_data=1; number_of_packet=0.
- Burst, count=3, gap=100: -> three frames; acq_enable low for 100 cycles between frames; number_of_packet=2; frames_done=3; single done_pulse.
- Timeout=500, no frame_sync -> ERROR at cycle ~502; timeout_err=1 held; done_pulse=1. Next start clears timeout_err.
- Continuous, gap=0; cmd_stop mid IN_FRAME after 5 frames -> current frame completes; frames_done=6; done_pulse; IDLE; no further acq_enable.
- Edges:
  - cmd_start+cmd_stop together in IDLE -> stays IDLE.
  - cfg_frame_count=0 in burst -> exactly 1 frame.
  - resetn low mid-GAP -> all outputs 0 at once, no done_pulse.
- frame_sync and frame_done coincident in WAIT_FRAME (burst count=2) -> counted; second frame follows.
